// File: rtl/port_request_queue_if.sv
// Bundle of client-side and cluster-side signals for one port_request_queue.
// Optional statistics outputs exist only when PORT_REQUEST_QUEUE_STATS_EN is defined.
interface port_request_queue_if;
  // client handshake
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_addr;
  logic [15:0] in_data;
  logic        in_wen;
  // cluster request side
  logic        mem_valid;
  logic [11:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_wen;
  logic [1:0]  mem_req_tag;
  // cluster control / response side
  logic        freeze_inputs;
  logic        resp_valid;
  logic [2:0]  outstanding;
  logic        resp_underflow;
`ifdef PORT_REQUEST_QUEUE_STATS_EN
  logic [15:0] stall_freeze_cnt;
  logic [15:0] stall_credit_cnt;
`endif

  // queue side
  modport slave (
    input  in_valid, in_addr, in_data, in_wen, freeze_inputs, resp_valid,
    output in_ready, mem_valid, mem_addr, mem_data_in, mem_wen, mem_req_tag,
           outstanding, resp_underflow
`ifdef PORT_REQUEST_QUEUE_STATS_EN
    , output stall_freeze_cnt, stall_credit_cnt
`endif
  );

  // client / cluster side
  modport master (
    output in_valid, in_addr, in_data, in_wen, freeze_inputs, resp_valid,
    input  in_ready, mem_valid, mem_addr, mem_data_in, mem_wen, mem_req_tag,
           outstanding, resp_underflow
`ifdef PORT_REQUEST_QUEUE_STATS_EN
    , input stall_freeze_cnt, stall_credit_cnt
`endif
  );
endinterface

// File: rtl/port_request_queue.sv
// Per-port request FIFO in front of the memory bank cluster. Buffers client
// requests, tags them with a rolling 2-bit tag, holds the head stable while the
// cluster freezes its inputs, and bounds issued-but-unanswered requests.
// Optional stall statistics: define PORT_REQUEST_QUEUE_STATS_EN.
module port_request_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  port_request_queue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]  tag_q, tag_d;
  logic [2:0]  outstanding_q, outstanding_d;
  logic        underflow_q, underflow_d;

  // Small distributed storage; the head must be visible on mem_* in the same
  // cycle it becomes the head, so reads are asynchronous.
  logic [11:0] addr_mem [DEPTH];
  logic [15:0] data_mem [DEPTH];
  logic        wen_mem  [DEPTH];

  logic        empty;
  logic        full;
  logic        credit_ok;
  logic        mem_valid_int;
  logic        push;
  logic        pop;
  logic        resp_counted;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  assign rd_idx        = rd_ptr_q[AW-1:0];
  assign wr_idx        = wr_ptr_q[AW-1:0];
  assign empty         = (wr_ptr_q == rd_ptr_q);
  assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign credit_ok     = (outstanding_q < 3'(MAX_OUTSTANDING));
  assign mem_valid_int = !empty && credit_ok;
  assign push          = bus.in_valid && !full;
  assign pop           = mem_valid_int && !bus.freeze_inputs;
  // A response with nothing outstanding is flagged but never decrements.
  assign resp_counted  = bus.resp_valid && (outstanding_q != 3'd0);

  // in_ready depends on registered pointers only.
  assign bus.in_ready       = !full;
  assign bus.mem_valid      = mem_valid_int;
  assign bus.mem_addr       = mem_valid_int ? addr_mem[rd_idx] : 12'd0;
  assign bus.mem_data_in    = mem_valid_int ? data_mem[rd_idx] : 16'd0;
  assign bus.mem_wen        = mem_valid_int ? wen_mem[rd_idx]  : 1'b0;
  assign bus.mem_req_tag    = mem_valid_int ? tag_q            : 2'd0;
  assign bus.outstanding    = outstanding_q;
  assign bus.resp_underflow = underflow_q;

  // Next-state for pointers, tag, credit count and underflow flag.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tag_d         = tag_q;
    outstanding_d = outstanding_q;
    underflow_d   = underflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      tag_d    = tag_q + 2'd1;
    end
    if (bus.resp_valid && (outstanding_q == 3'd0)) begin
      underflow_d = 1'b1;
    end
    case ({pop, resp_counted})
      2'b10:   outstanding_d = outstanding_q + 3'd1;
      2'b01:   outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tag_q         <= 2'd0;
      outstanding_q <= 3'd0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tag_q         <= tag_d;
      outstanding_q <= outstanding_d;
      underflow_q   <= underflow_d;
    end
  end

  // Payload storage write; contents need no reset since pointers gate use.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_idx] <= bus.in_addr;
      data_mem[wr_idx] <= bus.in_data;
      wen_mem[wr_idx]  <= bus.in_wen;
    end
  end

`ifdef PORT_REQUEST_QUEUE_STATS_EN
  logic [15:0] stall_freeze_cnt_q, stall_freeze_cnt_d;
  logic [15:0] stall_credit_cnt_q, stall_credit_cnt_d;

  assign bus.stall_freeze_cnt = stall_freeze_cnt_q;
  assign bus.stall_credit_cnt = stall_credit_cnt_q;

  // Saturating stall counters for freeze and credit exhaustion.
  always_comb begin
    stall_freeze_cnt_d = stall_freeze_cnt_q;
    stall_credit_cnt_d = stall_credit_cnt_q;
    if (!empty && bus.freeze_inputs && (stall_freeze_cnt_q != 16'hFFFF)) begin
      stall_freeze_cnt_d = stall_freeze_cnt_q + 16'd1;
    end
    if (!empty && (outstanding_q == 3'(MAX_OUTSTANDING)) && (stall_credit_cnt_q != 16'hFFFF)) begin
      stall_credit_cnt_d = stall_credit_cnt_q + 16'd1;
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_freeze_cnt_q <= 16'd0;
      stall_credit_cnt_q <= 16'd0;
    end else begin
      stall_freeze_cnt_q <= stall_freeze_cnt_d;
      stall_credit_cnt_q <= stall_credit_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_port_request_queue.sv
// Bench for port_request_queue: a table of directed vectors, hand-written
// corner sequences, and random traffic against a queue-based reference model.
module tb_port_request_queue;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  port_request_queue_if bus ();

  port_request_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
    logic        wen;
  } req_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [1:0]  tag;
  } obs_t;

  typedef struct {
    logic        iv; logic [11:0] a; logic [15:0] d; logic w; logic fz; logic rs;
    logic        e_rdy; logic e_mv; logic [11:0] e_a; logic [15:0] e_d; logic e_w;
    logic [1:0]  e_t; logic [2:0] e_o; logic e_uf;
  } vec_t;

  // reference model state
  req_t mq[$];
  int   m_outs;
  int   m_tag;
  bit   m_uf;
  bit   m_pushed;
  int   m_sf;
  int   m_sc;

  obs_t obs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_mv();
    return (mq.size() > 0) && (m_outs < MAXO);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit issue;
    bit nonempty;
    bit resp;
    if (reset) begin
      mq.delete(); m_outs = 0; m_tag = 0; m_uf = 0; m_sf = 0; m_sc = 0; m_pushed = 0;
      return;
    end
    nonempty = mq.size() > 0;
    resp     = bus.resp_valid;
    issue    = model_mv() && !bus.freeze_inputs;
    m_pushed = bus.in_valid && (mq.size() < DEPTH);
    if (nonempty && bus.freeze_inputs && m_sf < 65535) m_sf++;
    if (nonempty && m_outs == MAXO && m_sc < 65535) m_sc++;
    if (resp && m_outs == 0) m_uf = 1;
    m_outs = m_outs + (issue ? 1 : 0) - ((resp && m_outs > 0) ? 1 : 0);
    if (issue) begin
      void'(mq.pop_front());
      m_tag = (m_tag + 1) % 4;
    end
    if (m_pushed) mq.push_back('{addr: bus.in_addr, data: bus.in_data, wen: bus.in_wen});
  endtask

  // Wait for the falling edge, compare all outputs to the model, log issues.
  task automatic sample(input string nm);
    bit mv;
    @(negedge clk);
    mv = model_mv();
    chk({nm, ".in_ready"},    32'(bus.in_ready),       32'(mq.size() < DEPTH));
    chk({nm, ".mem_valid"},   32'(bus.mem_valid),      32'(mv));
    chk({nm, ".mem_addr"},    32'(bus.mem_addr),       mv ? 32'(mq[0].addr) : 32'd0);
    chk({nm, ".mem_data"},    32'(bus.mem_data_in),    mv ? 32'(mq[0].data) : 32'd0);
    chk({nm, ".mem_wen"},     32'(bus.mem_wen),        mv ? 32'(mq[0].wen)  : 32'd0);
    chk({nm, ".mem_tag"},     32'(bus.mem_req_tag),    mv ? 32'(m_tag)      : 32'd0);
    chk({nm, ".outstanding"}, 32'(bus.outstanding),    32'(m_outs));
    chk({nm, ".underflow"},   32'(bus.resp_underflow), 32'(m_uf));
    if (bus.mem_valid === 1'b1 && bus.freeze_inputs === 1'b0) begin
      obs.push_back('{addr: bus.mem_addr, tag: bus.mem_req_tag});
      $display("issue addr=%03h data=%04h wen=%0b tag=%0d", bus.mem_addr, bus.mem_data_in,
               bus.mem_wen, bus.mem_req_tag);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_addr = 0; bus.in_data = 0; bus.in_wen = 0;
    bus.freeze_inputs = 0; bus.resp_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    adv();
    reset = 1'b0;
  endtask

  task automatic push_cycle(input string nm, input logic [11:0] a);
    bus.in_valid = 1; bus.in_addr = a; bus.in_data = {4'h0, a}; bus.in_wen = a[0];
    sample(nm);
    adv();
    bus.in_valid = 0;
  endtask

  vec_t tbl[15];

  initial begin
    reset = 1'b1;
    idle_inputs();

    // inputs: iv a d w fz rs | expected: rdy mv a d w tag outs uf
    tbl[0]  = '{1, 12'h123, 16'h0000, 0, 0, 0,  1, 0, 12'h000, 16'h0000, 0, 0, 0, 0};
    tbl[1]  = '{0, 12'h000, 16'h0000, 0, 0, 0,  1, 1, 12'h123, 16'h0000, 0, 0, 0, 0};
    tbl[2]  = '{0, 12'h000, 16'h0000, 0, 0, 0,  1, 0, 12'h000, 16'h0000, 0, 0, 1, 0};
    tbl[3]  = '{0, 12'h000, 16'h0000, 0, 0, 1,  1, 0, 12'h000, 16'h0000, 0, 0, 1, 0};
    tbl[4]  = '{0, 12'h000, 16'h0000, 0, 0, 0,  1, 0, 12'h000, 16'h0000, 0, 0, 0, 0};
    tbl[5]  = '{0, 12'h000, 16'h0000, 0, 0, 1,  1, 0, 12'h000, 16'h0000, 0, 0, 0, 0};
    tbl[6]  = '{0, 12'h000, 16'h0000, 0, 0, 0,  1, 0, 12'h000, 16'h0000, 0, 0, 0, 1};
    tbl[7]  = '{1, 12'h0A5, 16'hBEEF, 1, 1, 0,  1, 0, 12'h000, 16'h0000, 0, 0, 0, 1};
    tbl[8]  = '{0, 12'h000, 16'h0000, 0, 1, 0,  1, 1, 12'h0A5, 16'hBEEF, 1, 1, 0, 1};
    tbl[9]  = '{0, 12'h000, 16'h0000, 0, 1, 0,  1, 1, 12'h0A5, 16'hBEEF, 1, 1, 0, 1};
    tbl[10] = '{0, 12'h000, 16'h0000, 0, 1, 0,  1, 1, 12'h0A5, 16'hBEEF, 1, 1, 0, 1};
    tbl[11] = '{0, 12'h000, 16'h0000, 0, 0, 0,  1, 1, 12'h0A5, 16'hBEEF, 1, 1, 0, 1};
    tbl[12] = '{0, 12'h000, 16'h0000, 0, 0, 0,  1, 0, 12'h000, 16'h0000, 0, 0, 1, 1};
    tbl[13] = '{0, 12'h000, 16'h0000, 0, 0, 1,  1, 0, 12'h000, 16'h0000, 0, 0, 1, 1};
    tbl[14] = '{0, 12'h000, 16'h0000, 0, 0, 0,  1, 0, 12'h000, 16'h0000, 0, 0, 0, 1};

    do_reset();

    // Directed table: single read, response, underflow, freeze hold.
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = tbl[i].iv; bus.in_addr = tbl[i].a; bus.in_data = tbl[i].d;
      bus.in_wen = tbl[i].w; bus.freeze_inputs = tbl[i].fz; bus.resp_valid = tbl[i].rs;
      @(negedge clk);
      $display("vec %0d rdy=%0b mv=%0b addr=%03h tag=%0d outs=%0d uf=%0b", i, bus.in_ready,
               bus.mem_valid, bus.mem_addr, bus.mem_req_tag, bus.outstanding, bus.resp_underflow);
      chk($sformatf("vec%0d.in_ready", i),    32'(bus.in_ready),       32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.mem_valid", i),   32'(bus.mem_valid),      32'(tbl[i].e_mv));
      chk($sformatf("vec%0d.mem_addr", i),    32'(bus.mem_addr),       32'(tbl[i].e_a));
      chk($sformatf("vec%0d.mem_data", i),    32'(bus.mem_data_in),    32'(tbl[i].e_d));
      chk($sformatf("vec%0d.mem_wen", i),     32'(bus.mem_wen),        32'(tbl[i].e_w));
      chk($sformatf("vec%0d.mem_tag", i),     32'(bus.mem_req_tag),    32'(tbl[i].e_t));
      chk($sformatf("vec%0d.outstanding", i), 32'(bus.outstanding),    32'(tbl[i].e_o));
      chk($sformatf("vec%0d.underflow", i),   32'(bus.resp_underflow), 32'(tbl[i].e_uf));
      adv();
    end
    idle_inputs();
    sample("post_table");
    adv();

    // Fill and order: freeze held, five pushes into a four-deep queue.
    do_reset();
    obs.delete();
    bus.freeze_inputs = 1;
    for (int i = 1; i <= 5; i++) begin
      bus.in_valid = 1; bus.in_addr = 12'(i); bus.in_data = 16'(i * 16); bus.in_wen = 1'(i);
      sample($sformatf("fill%0d", i));
      chk($sformatf("fill%0d.ready_const", i), 32'(bus.in_ready), 32'(i <= 4));
      adv();
    end
    // Release freeze; keep offering request 5 until accepted; answer every issue.
    bus.freeze_inputs = 0;
    for (int c = 0; c < 40 && obs.size() < 5; c++) begin
      bus.resp_valid = (m_outs > 0);
      sample("drain");
      adv();
      if (m_pushed) bus.in_valid = 0;
    end
    idle_inputs();
    chk("order.count", 32'(obs.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      chk($sformatf("order%0d.addr", i), 32'(obs[i].addr), 32'(i + 1));
      chk($sformatf("order%0d.tag", i),  32'(obs[i].tag),  32'(i % 4));
    end
    for (int c = 0; c < 4; c++) begin
      bus.resp_valid = (m_outs > 0);
      sample("drain_tail");
      adv();
    end
    idle_inputs();

    // Credit limit with MAX_OUTSTANDING = 2, then same-cycle issue + response.
    do_reset();
    push_cycle("cred_p0", 12'h201);
    push_cycle("cred_p1", 12'h202);
    push_cycle("cred_p2", 12'h203);
    sample("cred_stall");
    chk("credit_stall.mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("credit_stall.outstanding", 32'(bus.outstanding), 32'd2);
    adv();
    bus.resp_valid = 1;
    sample("cred_resp");
    chk("credit_resp.mem_valid", 32'(bus.mem_valid), 32'd0);
    adv();
    sample("cred_resume");
    chk("credit_resume.mem_valid", 32'(bus.mem_valid), 32'd1);
    chk("credit_resume.addr", 32'(bus.mem_addr), 32'h203);
    adv();
    bus.resp_valid = 0;
    sample("same_cycle");
    chk("issue_resp_same.outstanding", 32'(bus.outstanding), 32'd1);
    adv();

    // Reset mid-run: three queued, two outstanding.
    do_reset();
    for (int i = 0; i < 5; i++) push_cycle($sformatf("mid_p%0d", i), 12'(12'h300 + i));
    sample("mid_before");
    chk("mid_before.outstanding", 32'(bus.outstanding), 32'd2);
    adv();
    do_reset();
    sample("mid_after");
    chk("mid_after.in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_after.mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("mid_after.outstanding", 32'(bus.outstanding), 32'd0);
    adv();
    push_cycle("mid_push", 12'h3AA);
    bus.resp_valid = 1;
    sample("mid_tag");
    chk("mid_tag.tag", 32'(bus.mem_req_tag), 32'd0);
    chk("mid_tag.mem_valid", 32'(bus.mem_valid), 32'd1);
    adv();
    bus.resp_valid = 0;
    sample("mid_uf");
    chk("post_reset_resp.underflow", 32'(bus.resp_underflow), 32'd1);
    adv();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid      = ($urandom_range(0, 99) < 60);
      bus.in_addr       = 12'($urandom);
      bus.in_data       = 16'($urandom);
      bus.in_wen        = 1'($urandom);
      bus.freeze_inputs = ($urandom_range(0, 99) < 30);
      bus.resp_valid    = (m_outs > 0) && ($urandom_range(0, 99) < 45);
      sample("rand");
      adv();
    end
    idle_inputs();
`ifdef PORT_REQUEST_QUEUE_STATS_EN
    @(negedge clk);
    chk("stats.freeze_cnt", 32'(bus.stall_freeze_cnt), 32'(m_sf));
    chk("stats.credit_cnt", 32'(bus.stall_credit_cnt), 32'(m_sc));
    adv();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
